// File: rtl/boruss_mmio_pkg.sv
// Shared constants for the boruss MMIO responder: register offsets, TCTRL/STATUS bit
// indices and the window decode helper.
package boruss_mmio_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned OFF_W  = 3;

    localparam logic [OFF_W-1:0] MMIO_LED    = 3'd0;
    localparam logic [OFF_W-1:0] MMIO_SW     = 3'd1;
    localparam logic [OFF_W-1:0] MMIO_SWEDGE = 3'd2;
    localparam logic [OFF_W-1:0] MMIO_TCNT   = 3'd3;
    localparam logic [OFF_W-1:0] MMIO_TCMP   = 3'd4;
    localparam logic [OFF_W-1:0] MMIO_TCTRL  = 3'd5;
    localparam logic [OFF_W-1:0] MMIO_STATUS = 3'd6;
    localparam logic [OFF_W-1:0] MMIO_PRESC  = 3'd7;

    localparam int unsigned TCTRL_W       = 3;
    localparam int unsigned TCTRL_EN      = 0;
    localparam int unsigned TCTRL_AUTOCLR = 1;
    localparam int unsigned TCTRL_IRQEN   = 2;

    localparam int unsigned STATUS_MATCH  = 0;
    localparam int unsigned STATUS_SWEDGE = 1;

    // The window is 8 bytes aligned, so only the upper five address bits take part.
    function automatic logic window_hit(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] base);
        return addr[ADDR_W-1:OFF_W] == base[ADDR_W-1:OFF_W];
    endfunction

endpackage

// File: rtl/boruss_mmio_timer.sv
// Prescaled 8-bit timer: pcnt prescaler, TCNT counter and compare producing a match pulse.
module boruss_mmio_timer
    import boruss_mmio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              autoclr,
    input  logic [DATA_W-1:0] tcmp,
    input  logic [DATA_W-1:0] presc,
    input  logic              clear_pcnt,
    output logic [DATA_W-1:0] tcnt,
    output logic              match_set_c
);

    logic [DATA_W-1:0] pcnt_q, pcnt_d;
    logic [DATA_W-1:0] tcnt_q, tcnt_d;
    logic [DATA_W-1:0] tcnt_inc;
    logic              tick;

    always_comb begin
        pcnt_d      = pcnt_q;
        tcnt_d      = tcnt_q;
        match_set_c = 1'b0;
        tick        = en && (pcnt_q == presc);
        tcnt_inc    = tcnt_q + DATA_W'(1);

        if (en) begin
            pcnt_d = tick ? '0 : pcnt_q + DATA_W'(1);
        end
        // A PRESC/TCTRL write restarts the prescale period.
        if (clear_pcnt) begin
            pcnt_d = '0;
        end

        if (tick) begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc == tcmp) begin
                match_set_c = 1'b1;
                if (autoclr) begin
                    tcnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt_q <= '0;
            tcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign tcnt = tcnt_q;

endmodule

// File: rtl/boruss_mmio_responder.sv
// CPU data-port responder for an 8-byte MMIO window: LED register, synchronised switches
// with sticky edge flags, and a prescaled timer with compare interrupt.
module boruss_mmio_responder
    import boruss_mmio_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = 8'hF0,
    parameter int unsigned SW_WIDTH    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data_address,
    input  logic [7:0]          data_in,
    input  logic                data_write_enable,
    input  logic                data_read_enable,
    output logic [7:0]          data_out,
    output logic                data_read_valid,
    input  logic [SW_WIDTH-1:0] switch_in,
    output logic [7:0]          led_out,
    output logic                irq
);

    logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sync_q, sync_d;
    logic [SW_WIDTH-1:0] sw_prev_q, sw_prev_d;
    logic [SW_WIDTH-1:0] swedge_q, swedge_d;
    logic [SW_WIDTH-1:0] sw_sync, sw_edge;
    logic [DATA_W-1:0]   led_q, led_d;
    logic [DATA_W-1:0]   tcmp_q, tcmp_d;
    logic [DATA_W-1:0]   presc_q, presc_d;
    logic [TCTRL_W-1:0]  tctrl_q, tctrl_d;
    logic                match_q, match_d;
    logic                irq_q, irq_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                valid_q, valid_d;

    logic [OFF_W-1:0]  off;
    logic              sel, wr_hit, rd_hit, clear_pcnt;
    logic [DATA_W-1:0] rd_data, tcnt;
    logic              match_set_c;

    boruss_mmio_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (tctrl_q[TCTRL_EN]),
        .autoclr     (tctrl_q[TCTRL_AUTOCLR]),
        .tcmp        (tcmp_q),
        .presc       (presc_q),
        .clear_pcnt  (clear_pcnt),
        .tcnt        (tcnt),
        .match_set_c (match_set_c)
    );

    // Read mux always sees pre-write register values.
    always_comb begin
        rd_data = '0;
        case (off)
            MMIO_LED:    rd_data = led_q;
            MMIO_SW:     rd_data = DATA_W'(sw_sync);
            MMIO_SWEDGE: rd_data = DATA_W'(swedge_q);
            MMIO_TCNT:   rd_data = tcnt;
            MMIO_TCMP:   rd_data = tcmp_q;
            MMIO_TCTRL:  rd_data = DATA_W'(tctrl_q);
            MMIO_STATUS: rd_data = DATA_W'({|swedge_q, match_q});
            MMIO_PRESC:  rd_data = presc_q;
            default:     rd_data = '0;
        endcase
    end

    always_comb begin
        off        = data_address[OFF_W-1:0];
        sel        = window_hit(data_address, BASE_ADDR);
        wr_hit     = sel && data_write_enable;
        rd_hit     = sel && data_read_enable;

        sync_d     = {sync_q[SYNC_STAGES-2:0], switch_in};
        sw_sync    = sync_q[SYNC_STAGES-1];
        sw_prev_d  = sw_sync;
        sw_edge    = sw_sync & ~sw_prev_q;

        led_d      = led_q;
        tcmp_d     = tcmp_q;
        presc_d    = presc_q;
        tctrl_d    = tctrl_q;
        swedge_d   = swedge_q | sw_edge;
        clear_pcnt = 1'b0;

        if (wr_hit) begin
            case (off)
                MMIO_LED:    led_d = data_in;
                // A fresh edge in the same cycle beats the W1C clear.
                MMIO_SWEDGE: swedge_d = (swedge_q & ~data_in[SW_WIDTH-1:0]) | sw_edge;
                MMIO_TCMP:   tcmp_d = data_in;
                MMIO_TCTRL: begin
                    tctrl_d    = data_in[TCTRL_W-1:0];
                    clear_pcnt = 1'b1;
                end
                MMIO_PRESC: begin
                    presc_d    = data_in;
                    clear_pcnt = 1'b1;
                end
                default: ;
            endcase
        end

        // A match set in the same cycle as a STATUS read survives the read-clear.
        match_d = match_q;
        if (rd_hit && (off == MMIO_STATUS)) begin
            match_d = 1'b0;
        end
        if (match_set_c) begin
            match_d = 1'b1;
        end

        irq_d      = match_d & tctrl_d[TCTRL_IRQEN];
        valid_d    = rd_hit;
        data_out_d = rd_hit ? rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q     <= '0;
            sw_prev_q  <= '0;
            swedge_q   <= '0;
            led_q      <= '0;
            tcmp_q     <= 8'hFF;
            presc_q    <= '0;
            tctrl_q    <= '0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sw_prev_q  <= sw_prev_d;
            swedge_q   <= swedge_d;
            led_q      <= led_d;
            tcmp_q     <= tcmp_d;
            presc_q    <= presc_d;
            tctrl_q    <= tctrl_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out        = data_out_q;
    assign data_read_valid = valid_q;
    assign led_out         = led_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_boruss_mmio_responder.sv
// Bench for boruss_mmio_responder: directed bus traffic, a register-level reference model
// compared every cycle, plus hand-computed literal checks.
module tb_boruss_mmio_responder;

    logic       clk;
    logic       reset;
    logic [7:0] data_address;
    logic [7:0] data_in;
    logic       data_write_enable;
    logic       data_read_enable;
    logic [7:0] data_out;
    logic       data_read_valid;
    logic [3:0] switch_in;
    logic [7:0] led_out;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    boruss_mmio_responder #(
        .BASE_ADDR   (8'hF0),
        .SW_WIDTH    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .data_address      (data_address),
        .data_in           (data_in),
        .data_write_enable (data_write_enable),
        .data_read_enable  (data_read_enable),
        .data_out          (data_out),
        .data_read_valid   (data_read_valid),
        .switch_in         (switch_in),
        .led_out           (led_out),
        .irq               (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register map state as plain variables.
    logic [7:0] m_reg [0:7];
    logic [7:0] m_pcnt;
    logic       m_match;
    logic [3:0] m_hist [0:2];
    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_irq;

    always @(posedge clk) begin
        logic [2:0] o;
        logic       hit, tick, set;
        logic [3:0] sw_now, edges;
        logic [7:0] rv, nxt;
        if (!reset) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
            m_reg[4] = 8'hFF;
            m_pcnt   = 0;
            m_match  = 0;
            for (int i = 0; i < 3; i++) m_hist[i] = 4'h0;
            m_dout = 0; m_valid = 0; m_irq = 0;
        end else begin
            o      = data_address[2:0];
            hit    = (data_address >= 8'hF0) && (data_address <= 8'hF7);
            sw_now = m_hist[1];
            edges  = sw_now & ~m_hist[2];
            case (o)
                3'd1:    rv = {4'h0, sw_now};
                3'd6:    rv = {6'b0, (m_reg[2] != 0), m_match};
                default: rv = m_reg[o];
            endcase
            m_valid = hit && data_read_enable;
            m_dout  = m_valid ? rv : 8'h00;

            // timer advances from the settings in force before this edge
            tick = m_reg[5][0] && (m_pcnt == m_reg[7]);
            set  = 0;
            if (m_reg[5][0]) m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
            if (tick) begin
                nxt = m_reg[3] + 8'd1;
                m_reg[3] = nxt;
                if (nxt == m_reg[4]) begin
                    set = 1;
                    if (m_reg[5][1]) m_reg[3] = 8'd0;
                end
            end
            if (m_valid && o == 3'd6) m_match = 0;
            if (set) m_match = 1;

            if (hit && data_write_enable && o == 3'd2)
                m_reg[2] = (m_reg[2] & ~{4'h0, data_in[3:0]}) | {4'h0, edges};
            else
                m_reg[2] = m_reg[2] | {4'h0, edges};
            if (hit && data_write_enable) begin
                case (o)
                    3'd0: m_reg[0] = data_in;
                    3'd4: m_reg[4] = data_in;
                    3'd5: begin m_reg[5] = {5'b0, data_in[2:0]}; m_pcnt = 0; end
                    3'd7: begin m_reg[7] = data_in; m_pcnt = 0; end
                    default: ;
                endcase
            end
            m_irq = m_match && m_reg[5][2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = switch_in;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model data_out", data_out, m_dout);
            check("model data_read_valid", {7'b0, data_read_valid}, {7'b0, m_valid});
            check("model led_out", led_out, m_reg[0]);
            check("model irq", {7'b0, irq}, {7'b0, m_irq});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        data_address = a; data_in = d; data_write_enable = 1'b1;
        cyc();
        data_write_enable = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic v);
        data_address = a; data_read_enable = 1'b1;
        cyc();
        data_read_enable = 1'b0;
        d = data_out;
        v = data_read_valid;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       v;
        rd(a, d, v);
        check({name, " valid"}, {7'b0, v}, 8'h01);
        check(name, d, exp);
    endtask

    initial begin
        logic [7:0] d;
        logic       v;
        reset = 1'b0; data_address = 8'h00; data_in = 8'h00;
        data_write_enable = 1'b0; data_read_enable = 1'b0; switch_in = 4'h0;
        cyc();
        chk_en = 1;
        cyc();
        check("reset led_out", led_out, 8'h00);
        check("reset irq", {7'b0, irq}, 8'h00);
        check("reset valid", {7'b0, data_read_valid}, 8'h00);
        check("reset data_out", data_out, 8'h00);
        reset = 1'b1;
        cyc();

        // LED write/read and same-cycle read+write
        wr(8'hF0, 8'hA5);
        check("led after write", led_out, 8'hA5);
        rd_chk("led read", 8'hF0, 8'hA5);
        data_address = 8'hF0; data_in = 8'h3C;
        data_write_enable = 1'b1; data_read_enable = 1'b1;
        cyc();
        data_write_enable = 1'b0; data_read_enable = 1'b0;
        check("rw same cycle old data", data_out, 8'hA5);
        check("rw same cycle new led", led_out, 8'h3C);

        // out-of-window accesses
        rd(8'h10, d, v);
        check("miss 0x10 valid", {7'b0, v}, 8'h00);
        check("miss 0x10 data", d, 8'h00);
        rd(8'hF8, d, v);
        check("miss 0xF8 valid", {7'b0, v}, 8'h00);
        check("miss 0xF8 data", d, 8'h00);
        wr(8'h10, 8'h55);
        check("miss write led", led_out, 8'h3C);
        wr(8'hF3, 8'h77);
        rd_chk("tcnt read-only", 8'hF3, 8'h00);
        rd_chk("tcmp reset", 8'hF4, 8'hFF);

        // timer match with autoclear; ticks every 3 cycles after the TCTRL write
        wr(8'hF7, 8'h02);
        wr(8'hF4, 8'h03);
        wr(8'hF5, 8'h07);
        wait_cyc(8);
        check("irq before match", {7'b0, irq}, 8'h00);
        cyc();
        check("irq at match", {7'b0, irq}, 8'h01);
        rd_chk("status match", 8'hF6, 8'h01);
        check("irq after status read", {7'b0, irq}, 8'h00);
        rd_chk("tcnt autocleared", 8'hF3, 8'h00);

        // status read lands on the next match tick: old value returned, set wins
        wait_cyc(6);
        rd_chk("status race old", 8'hF6, 8'h00);
        check("irq after race", {7'b0, irq}, 8'h01);
        rd_chk("status after race", 8'hF6, 8'h01);
        wr(8'hF5, 8'h00);
        check("irq after disable", {7'b0, irq}, 8'h00);

        // switches and sticky edges
        switch_in = 4'b0100;
        wait_cyc(3);
        rd_chk("sw sync", 8'hF1, 8'h04);
        rd_chk("swedge set", 8'hF2, 8'h04);
        rd_chk("status swedge", 8'hF6, 8'h02);
        wr(8'hF2, 8'h04);
        rd_chk("swedge cleared", 8'hF2, 8'h00);
        switch_in = 4'b0000;
        wait_cyc(3);
        rd_chk("swedge on fall", 8'hF2, 8'h00);
        switch_in = 4'b0100;
        wait_cyc(3);
        rd_chk("swedge again", 8'hF2, 8'h04);

        // reset mid-run with a read pending
        wr(8'hF0, 8'hFF);
        wr(8'hF7, 8'h00);
        wr(8'hF4, 8'h02);
        wr(8'hF5, 8'h07);
        wait_cyc(3);
        check("led before reset", led_out, 8'hFF);
        reset = 1'b0;
        data_address = 8'hF0; data_read_enable = 1'b1;
        cyc();
        data_read_enable = 1'b0;
        check("mid reset led", led_out, 8'h00);
        check("mid reset irq", {7'b0, irq}, 8'h00);
        check("mid reset valid", {7'b0, data_read_valid}, 8'h00);
        check("mid reset data_out", data_out, 8'h00);
        reset = 1'b1;
        rd_chk("tcmp after reset", 8'hF4, 8'hFF);
        rd_chk("tcnt after reset", 8'hF3, 8'h00);
        wait_cyc(4);
        rd_chk("tcnt holds", 8'hF3, 8'h00);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
